shl_unit: RTL

Multi-cycle left-shift/rotate-left execution unit for the Mini-SRC datapath. It is the left-direction counterpart to the combinational arithmetic right shifter. It shifts at most STEP bit positions per clock under a start/done handshake, so the ALU control sequencer can issue `shl` and `rol` without a full 32-bit barrel shifter. Result is registered and held until the next accepted start.

---
 rtl/shl_unit_if.sv | 21 ++
 rtl/shl_unit.sv | 81 ++++++++
 2 files changed

// File: rtl/shl_unit_if.sv
// Handshake and operand bundle between the ALU control sequencer (master)
// and the multi-cycle left shifter (slave).
interface shl_unit_if;
  logic        start;
  logic        op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        busy;
  logic        done;

  modport master (
    output start, op, A, B,
    input  Result, busy, done
  );

  modport slave (
    input  start, op, A, B,
    output Result, busy, done
  );
endinterface

// File: rtl/shl_unit.sv
// Multi-cycle SHL / ROL unit: moves at most STEP bit positions per clock
// instead of using a full 32-bit barrel shifter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; Result holds the last completed value
// SHIFT | shifting work by min(STEP, n) per edge; n == 0 -> finish
module shl_unit #(
  parameter int STEP = 4
) (
  input  logic       clock,
  input  logic       clear,
  shl_unit_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t      state;
  logic        op_r;
  logic [31:0] work;
  logic [4:0]  n;
  logic [4:0]  k;
  logic [31:0] work_next;

  // Per-edge shift distance and the shifted working value. k is never 0 when
  // work_next is used, so the rotate's right shift never degenerates.
  always_comb begin
    k         = (n < STEP_W) ? n : STEP_W;
    work_next = work << k;
    if (op_r) begin
      work_next = (work << k) | (work >> (6'd32 - {1'b0, k}));
    end
  end

  // Sequencer: captures operands in IDLE, shifts in SHIFT, publishes Result.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      op_r       <= 1'b0;
      work       <= '0;
      n          <= '0;
      bus.Result <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r     <= bus.op;
            bus.busy <= 1'b1;
            state    <= SHIFT;
            // A logical shift by 32 or more empties the word; rotate wraps mod 32.
            if (!bus.op && (bus.B >= 32'd32)) begin
              work <= '0;
              n    <= '0;
            end else begin
              work <= bus.A;
              n    <= bus.B[4:0];
            end
          end
        end
        SHIFT: begin
          if (n != 5'd0) begin
            work <= work_next;
            n    <= n - k;
          end else begin
            bus.Result <= work;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
